fracdiv_scheduler: RTL and testbench
====================================

# fracdiv_scheduler

Programmable dual-modulus scheduler for the fractional clock-divider path: it divides the input clock by N + NUM/DEN on average by sequencing periods of N and N+1 input cycles. The long/short decision for each period comes from a first-order accumulator. Configuration is loaded through a valid/ready handshake and applied only at superframe boundaries, so a reconfiguration never produces a runt or stretched period. It replaces hard-coded 3/4 sequencing, for example the pi divider with N=3, NUM=177, DEN=1250.

## Interface
- INT_W, 4: width of the integer divisor N.
- FRAC_W, 11: width of NUM and DEN.
- clk  in  1  input clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  a configuration is offered on cfg_int/cfg_num/cfg_den.
- cfg_ready  out  1  the block can take a configuration; a transfer happens when cfg_valid and cfg_ready are both high.
- cfg_int  in  INT_W  integer divisor N; legal range is N ≥ 2.
- cfg_num  in  FRAC_W  fractional numerator; legal range is NUM < DEN.
- cfg_den  in  FRAC_W  fractional denominator; legal range is DEN ≥ 1.
- en  in  1  run request.
- div_pulse  out  1  one-cycle pulse in the last input cycle of every output period.
- mod_sel  out  1  high for the whole of a long (N+1) period.
- sf_done  out  1  one-cycle pulse coincident with the div_pulse that ends period number DEN of a superframe.
- busy  out  1  the state is RUN.
- cfg_err  out  1  one-cycle pulse when an illegal configuration is rejected.

## Operation
- Registers:
  - active config {cur_int, cur_num, cur_den} plus a cfg_loaded flag.
  - one pending slot {pend_*} plus a pend_v flag.
  - accumulator acc, FRAC_W+1 bits; acc+num must never overflow.
  - phase counter ph, INT_W+1 bits.
  - period counter pc, FRAC_W bits.
- Handshake:
  - cfg_ready = !pend_v.
  - An accepted word is checked for N ≥ 2, DEN ≥ 1 and NUM < DEN.
  - An illegal word is dropped: cfg_err pulses the following cycle and state is unchanged.
  - A legal word is written to pend_v/pend_*.
- State machine with two states, IDLE and RUN.
- IDLE:
  - If pend_v is set, the pending config moves to active: pend_v clears, cfg_loaded sets.
  - acc=0, ph=0, pc=0.
  - Go to RUN when en=1 and cfg_loaded=1, or when en=1 and a transfer into active happens in the same cycle.
- RUN, period start (ph=0):
  - s = acc + cur_num.
  - If s ≥ cur_den: the period is long (L = N+1), mod_sel=1, acc ← s − cur_den.
  - Otherwise: the period is short (L = N), mod_sel=0, acc ← s.
- RUN, every cycle:
  - ph increments.
  - At ph = L−1: div_pulse=1, ph ← 0, pc increments.
- Superframe end: when pc = cur_den−1 and a period ends:
  - sf_done=1 and pc ← 0. acc is 0 at this point by construction.
  - If pend_v is set, the pending config becomes active for the next period with no gap.
- en deasserted during RUN: the current period completes, including its div_pulse, and the block then enters IDLE. acc and pc are cleared, so a restart is deterministic.
- Simultaneous events:
  - A config transfer in the same cycle as a superframe end is captured to pending and applied at the next boundary.
  - A new config is never applied mid-superframe.
- Arithmetic: all unsigned; ph is compared against the registered L.

## Timing
- Reset values: cfg_ready=1, div_pulse=0, mod_sel=0, sf_done=0, busy=0, cfg_err=0, state IDLE, all counters 0, cfg_loaded=0, pend_v=0.
- An asynchronous reset during RUN stops div_pulse immediately; there is no partial-period completion.
- Start:
  - en sampled high at edge k in IDLE with a config loaded.
  - busy=1 and ph=0 after edge k.
  - The first div_pulse is in cycle k+L, i.e. the L-th cycle after entry.
- Pulse spacing equals the period length L exactly; there are no idle cycles between periods.
- Config latency:
  - IDLE: pending becomes active 1 cycle after acceptance.
  - RUN: it becomes active at the next superframe boundary.
- cfg_err appears 1 cycle after the rejected transfer.
- Average output frequency is f_clk·DEN/(N·DEN+NUM).

## Test plan
- N=3, NUM=1, DEN=2, en=1: periods alternate 3, 4, 3, 4, … cycles with mod_sel=0, 1, …; sf_done every 7 cycles, on the 2nd pulse.
- N=3, NUM=177, DEN=1250: exactly 1250 div_pulses and one sf_done in 3927 cycles; 177 long periods; acc=0 at sf_done.
- Reconfigure to N=4, NUM=0, DEN=1 mid-superframe:
  - cfg_ready drops until the boundary.
  - Old spacing is kept until sf_done, then every period is 4 cycles with no runt.
- Illegal configs each get one cfg_err pulse and leave the active config unchanged:
  - N=1;
  - NUM=5 with DEN=5;
  - DEN=0.
- With N=3, NUM=1, DEN=2, deassert en at ph=1 of a long period: the period completes (pulse 3 cycles later), then IDLE. Re-enabling restarts with a short period.
- Assert rst_n low mid-RUN: all outputs reach their reset values asynchronously and cfg_loaded=0. With en=1 and no config, the block stays idle.

Source files
------------

// File: rtl/fracdiv_scheduler_if.sv
// Configuration handshake bundle for the fractional divider scheduler.
// The master offers {int,num,den}; the slave accepts when ready.
interface fracdiv_scheduler_if #(
  parameter int INT_W  = 4,
  parameter int FRAC_W = 11
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [INT_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_num;
  logic [FRAC_W-1:0] cfg_den;

  modport master (
    output cfg_valid, cfg_int, cfg_num, cfg_den,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_int, cfg_num, cfg_den,
    output cfg_ready
  );
endinterface

// File: rtl/fracdiv_scheduler.sv
// Dual-modulus N / N+1 period scheduler driven by a first-order accumulator.
// New configurations are held pending and swapped in only at superframe ends.
module fracdiv_scheduler #(
  parameter int INT_W  = 4,
  parameter int FRAC_W = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  fracdiv_scheduler_if.slave  cfg,
  input  logic                en,
  output logic                div_pulse,
  output logic                mod_sel,
  output logic                sf_done,
  output logic                busy,
  output logic                cfg_err
);

  localparam int PH_W  = INT_W + 1;
  localparam int ACC_W = FRAC_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [INT_W-1:0]  cur_int_q, cur_int_d;
  logic [FRAC_W-1:0] cur_num_q, cur_num_d;
  logic [FRAC_W-1:0] cur_den_q, cur_den_d;
  logic [INT_W-1:0]  pend_int_q, pend_int_d;
  logic [FRAC_W-1:0] pend_num_q, pend_num_d;
  logic [FRAC_W-1:0] pend_den_q, pend_den_d;
  logic              loaded_q, loaded_d;
  logic              pend_v_q, pend_v_d;
  logic              long_q, long_d;
  logic              err_q, err_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [PH_W-1:0]   len_q, len_d;
  logic [FRAC_W-1:0] pc_q, pc_d;

  logic [ACC_W-1:0]  sum;
  logic [PH_W-1:0]   len_now;
  logic              long_now;
  logic              xfer;
  logic              legal;
  logic              period_end;
  logic              sf_end;

  assign cfg.cfg_ready = !pend_v_q;
  assign busy          = (state_q == RUN);
  assign cfg_err       = err_q;

  // Handshake capture, period decision and state sequencing.
  always_comb begin
    state_d    = state_q;
    cur_int_d  = cur_int_q;
    cur_num_d  = cur_num_q;
    cur_den_d  = cur_den_q;
    pend_int_d = pend_int_q;
    pend_num_d = pend_num_q;
    pend_den_d = pend_den_q;
    loaded_d   = loaded_q;
    pend_v_d   = pend_v_q;
    long_d     = long_q;
    acc_d      = acc_q;
    ph_d       = ph_q;
    len_d      = len_q;
    pc_d       = pc_q;
    div_pulse  = 1'b0;
    mod_sel    = 1'b0;
    sf_done    = 1'b0;

    xfer  = cfg.cfg_valid && !pend_v_q;
    legal = (cfg.cfg_int >= INT_W'(2))
         && (cfg.cfg_den != '0)
         && (cfg.cfg_num < cfg.cfg_den);
    err_d = xfer && !legal;

    sum      = acc_q + ACC_W'(cur_num_q);
    long_now = (sum >= ACC_W'(cur_den_q));
    len_now  = (ph_q == '0)
             ? PH_W'(cur_int_q) + PH_W'(long_now)
             : len_q;
    // len_now >= 2, so a period can never end in its first cycle.
    period_end = (state_q == RUN)
              && (ph_q == len_now - PH_W'(1));
    sf_end     = period_end
              && (pc_q == cur_den_q - FRAC_W'(1));

    if (xfer && legal) begin
      pend_int_d = cfg.cfg_int;
      pend_num_d = cfg.cfg_num;
      pend_den_d = cfg.cfg_den;
      pend_v_d   = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        acc_d  = '0;
        ph_d   = '0;
        pc_d   = '0;
        long_d = 1'b0;
        if (pend_v_q) begin
          cur_int_d = pend_int_q;
          cur_num_d = pend_num_q;
          cur_den_d = pend_den_q;
          pend_v_d  = 1'b0;
          loaded_d  = 1'b1;
        end
        if (en && (loaded_q || pend_v_q)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        mod_sel = (ph_q == '0) ? long_now : long_q;
        ph_d    = ph_q + PH_W'(1);
        if (ph_q == '0) begin
          len_d  = len_now;
          long_d = long_now;
          acc_d  = long_now ? sum - ACC_W'(cur_den_q) : sum;
        end
        if (period_end) begin
          div_pulse = 1'b1;
          ph_d      = '0;
          pc_d      = pc_q + FRAC_W'(1);
          if (sf_end) begin
            sf_done = 1'b1;
            pc_d    = '0;
            if (pend_v_q) begin
              cur_int_d = pend_int_q;
              cur_num_d = pend_num_q;
              cur_den_d = pend_den_q;
              pend_v_d  = 1'b0;
            end
          end
          if (!en) begin
            state_d = IDLE;
            acc_d   = '0;
            pc_d    = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_int_q  <= '0;
      cur_num_q  <= '0;
      cur_den_q  <= '0;
      pend_int_q <= '0;
      pend_num_q <= '0;
      pend_den_q <= '0;
      loaded_q   <= 1'b0;
      pend_v_q   <= 1'b0;
      long_q     <= 1'b0;
      err_q      <= 1'b0;
      acc_q      <= '0;
      ph_q       <= '0;
      len_q      <= '0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      cur_int_q  <= cur_int_d;
      cur_num_q  <= cur_num_d;
      cur_den_q  <= cur_den_d;
      pend_int_q <= pend_int_d;
      pend_num_q <= pend_num_d;
      pend_den_q <= pend_den_d;
      loaded_q   <= loaded_d;
      pend_v_q   <= pend_v_d;
      long_q     <= long_d;
      err_q      <= err_d;
      acc_q      <= acc_d;
      ph_q       <= ph_d;
      len_q      <= len_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_fracdiv_scheduler.sv
// Bench for fracdiv_scheduler: period lengths, mod_sel and sf_done
// are compared against an arithmetic floor((j+1)NUM/DEN) model.
module tb_fracdiv_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic div_pulse, mod_sel, sf_done, busy, cfg_err;
  int   checks = 0;
  int   errors = 0;

  int cl[$];
  bit cm[$];
  bit cst[$];
  bit csf[$];
  bit crdy[$];

  fracdiv_scheduler_if #(.INT_W(4), .FRAC_W(11)) cfg_if ();

  fracdiv_scheduler #(.INT_W(4), .FRAC_W(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (cfg_if),
    .en        (en),
    .div_pulse (div_pulse),
    .mod_sel   (mod_sel),
    .sf_done   (sf_done),
    .busy      (busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  // Reference: period j of a superframe is long iff floor crosses.
  function automatic bit m_long(int j, int num, int den);
    return (((j + 1) * num) / den) != ((j * num) / den);
  endfunction

  function automatic int m_len(int j, int n, int num, int den);
    return n + (m_long(j, num, den) ? 1 : 0);
  endfunction

  // Observe nper periods starting at the first cycle of a period.
  task automatic capture(input int nper);
    int c;
    bit m, st, got, sf, rdy;
    cl.delete(); cm.delete(); cst.delete();
    csf.delete(); crdy.delete();
    for (int p = 0; p < nper; p++) begin
      c = 0; st = 1; got = 0; sf = 0; rdy = 0;
      m = mod_sel;
      while (!got && c < 40) begin
        c++;
        if (mod_sel !== m) st = 0;
        if (div_pulse === 1'b1) begin
          got = 1; sf = sf_done; rdy = cfg_ready_w();
        end
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
      end
      cl.push_back(got ? c : -1);
      cm.push_back(m);
      cst.push_back(st);
      csf.push_back(sf);
      crdy.push_back(rdy);
    end
  endtask

  function automatic bit cfg_ready_w();
    return cfg_if.cfg_ready;
  endfunction

  task automatic send_cfg(input int n, input int num, input int den,
                          output bit ok);
    int t;
    t = 0;
    cfg_if.cfg_int   = 4'(n);
    cfg_if.cfg_num   = 11'(num);
    cfg_if.cfg_den   = 11'(den);
    cfg_if.cfg_valid = 1'b1;
    while (cfg_if.cfg_ready !== 1'b1 && t < 5000) begin
      @(negedge clk); t++;
    end
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    ok = (t < 5000);
  endtask

  task automatic stop_run(output bit ok);
    int t;
    t = 0;
    en = 1'b0;
    while (busy === 1'b1 && t < 100) begin
      @(negedge clk); t++;
    end
    ok = (busy === 1'b0);
  endtask

  // Compare captured periods against one config, j offset j0.
  task automatic cmp_run(input string nm, input int n, input int num,
                         input int den, input int j0);
    int bl, bm, bs, j;
    bl = -1; bm = -1; bs = -1;
    for (int p = 0; p < cl.size(); p++) begin
      j = (p + j0) % den;
      if (bl < 0 && cl[p] != m_len(j, n, num, den)) bl = p;
      if (bm < 0 && (cm[p] != m_long(j, num, den) || !cst[p])) bm = p;
      if (bs < 0 && csf[p] != (j == den - 1)) bs = p;
    end
    checks++;
    if (bl >= 0) begin
      errors++;
      $display("FAIL %s_len: period %0d got %0d expected %0d", nm, bl,
               cl[bl], m_len((bl + j0) % den, n, num, den));
    end
    checks++;
    if (bm >= 0) begin
      errors++;
      $display("FAIL %s_mod: period %0d got mod=%0b stable=%0b expected %0b",
               nm, bm, cm[bm], cst[bm], m_long((bm + j0) % den, num, den));
    end
    checks++;
    if (bs >= 0) begin
      errors++;
      $display("FAIL %s_sf: period %0d got %0b expected %0b", nm, bs,
               csf[bs], ((bs + j0) % den) == den - 1);
    end
  endtask

  task automatic test_reset();
    int act;
    checks++;
    if ({cfg_if.cfg_ready, div_pulse, mod_sel, sf_done, busy, cfg_err}
        !== 6'b100000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 100000",
               {cfg_if.cfg_ready, div_pulse, mod_sel, sf_done, busy, cfg_err});
    end
    act = 0;
    en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || div_pulse !== 1'b0) act++;
    end
    en = 1'b0;
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL reset_noconfig_idle: active cycles %0d expected 0", act);
    end
  endtask

  task automatic test_basic();
    bit ok;
    send_cfg(3, 1, 2, ok);
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: busy %b ok %0b expected 1", busy, ok);
    end
    capture(8);
    cmp_run("basic", 3, 1, 2, 0);
  endtask

  task automatic test_pi();
    bit ok;
    int tot, nl, nsf;
    stop_run(ok);
    send_cfg(3, 177, 1250, ok);
    en = 1'b1;
    @(negedge clk);
    capture(1251);
    tot = 0; nl = 0; nsf = 0;
    for (int p = 0; p < 1250; p++) begin
      tot += cl[p]; nl += cm[p]; nsf += csf[p];
    end
    checks++;
    if (tot != 3927) begin
      errors++;
      $display("FAIL pi_cycles: got %0d expected 3927", tot);
    end
    checks++;
    if (nl != 177) begin
      errors++;
      $display("FAIL pi_long_count: got %0d expected 177", nl);
    end
    checks++;
    if (nsf != 1 || !csf[1249]) begin
      errors++;
      $display("FAIL pi_sf_count: got %0d last %0b expected 1 1",
               nsf, csf[1249]);
    end
    cmp_run("pi", 3, 177, 1250, 0);
  endtask

  // Entered at the first cycle of period j=1 of a pi superframe.
  task automatic test_reconfig();
    int bl, br, el;
    bit er, ok;
    cfg_if.cfg_int   = 4'd4;
    cfg_if.cfg_num   = 11'd0;
    cfg_if.cfg_den   = 11'd1;
    cfg_if.cfg_valid = 1'b1;
    capture(1255);
    bl = -1; br = -1;
    for (int p = 0; p < 1255; p++) begin
      el = (p < 1249) ? m_len(p + 1, 3, 177, 1250) : 4;
      er = (p >= 1249);
      if (bl < 0 && (cl[p] != el || csf[p] != (p >= 1248))) bl = p;
      if (br < 0 && crdy[p] != er) br = p;
    end
    checks++;
    if (bl >= 0) begin
      errors++;
      $display("FAIL reconfig_seq: period %0d len %0d sf %0b", bl,
               cl[bl], csf[bl]);
    end
    checks++;
    if (br >= 0) begin
      errors++;
      $display("FAIL reconfig_ready: period %0d got %0b", br, crdy[br]);
    end
    stop_run(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reconfig_stop: busy %b expected 0", busy);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    int tn[3], tu[3], td[3];
    tn = '{1, 3, 3};
    tu = '{0, 5, 0};
    td = '{1, 5, 0};
    for (int i = 0; i < 3; i++) begin
      send_cfg(tn[i], tu[i], td[i], ok);
      checks++;
      if (cfg_err !== 1'b1 || cfg_if.cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL illegal_err%0d: err %b ready %b expected 1 1",
                 i, cfg_err, cfg_if.cfg_ready);
      end
      @(negedge clk);
      checks++;
      if (cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL illegal_pulse%0d: err %b expected 0", i, cfg_err);
      end
    end
    en = 1'b1;
    @(negedge clk);
    capture(4);
    cmp_run("illegal_keep", 4, 0, 1, 0);
  endtask

  task automatic test_en_drop();
    bit ok;
    int c;
    stop_run(ok);
    send_cfg(3, 1, 2, ok);
    en = 1'b1;
    @(negedge clk);
    capture(1);
    @(negedge clk);
    en = 1'b0;
    checks++;
    if (cl[0] != 3 || mod_sel !== 1'b1) begin
      errors++;
      $display("FAIL endrop_long: first %0d mod %b expected 3 1",
               cl[0], mod_sel);
    end
    c = 1;
    while (div_pulse !== 1'b1 && c < 20) begin
      @(negedge clk); c++;
    end
    checks++;
    if (c != 3) begin
      errors++;
      $display("FAIL endrop_finish: pulse after %0d expected 3", c);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL endrop_idle: busy %b expected 0", busy);
    end
    en = 1'b1;
    @(negedge clk);
    capture(2);
    cmp_run("restart", 3, 1, 2, 0);
  endtask

  task automatic test_random();
    bit ok;
    int n, num, den;
    for (int r = 0; r < 5; r++) begin
      n   = $urandom_range(2, 7);
      den = $urandom_range(1, 12);
      num = $urandom_range(0, den - 1);
      stop_run(ok);
      send_cfg(n, num, den, ok);
      en = 1'b1;
      @(negedge clk);
      capture(2 * den + 1);
      cmp_run($sformatf("rand%0d", r), n, num, den, 0);
    end
  endtask

  task automatic test_async_reset();
    int t, act;
    t = 0;
    while (div_pulse !== 1'b1 && t < 40) begin
      @(negedge clk); t++;
    end
    checks++;
    if (div_pulse !== 1'b1) begin
      errors++;
      $display("FAIL areset_find: no pulse, got %b expected 1", div_pulse);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_if.cfg_ready, div_pulse, mod_sel, sf_done, busy, cfg_err}
        !== 6'b100000) begin
      errors++;
      $display("FAIL areset_outputs: got %b expected 100000",
               {cfg_if.cfg_ready, div_pulse, mod_sel, sf_done, busy, cfg_err});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || div_pulse !== 1'b0) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL areset_unloaded: active cycles %0d expected 0", act);
    end
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_int   = '0;
    cfg_if.cfg_num   = '0;
    cfg_if.cfg_den   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_pi();
    test_reconfig();
    test_illegal();
    test_en_drop();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
